// File: rtl/rip_wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rip_wb_pkg
//  Description : Shared types and constants for the register-file writeback
//                arbiter (request record, x0 index, register count and a
//                destination-to-one-hot helper).
//  Revision    : 1.0 - initial release
// ============================================================================
package rip_wb_pkg;

    // Default datapath width; the arbiter itself is parameterised separately.
    localparam int WB_XLEN = 32;

    localparam logic [4:0] REG_X0   = 5'd0;
    localparam int         NUM_REGS = 32;

    typedef struct packed {
        logic [4:0]         rd;
        logic [WB_XLEN-1:0] data;
    } wb_req_t;

    // One-hot register mask for a destination index.
    function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [4:0] rd);
        logic [NUM_REGS-1:0] v;
        v     = '0;
        v[rd] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rip_wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rip_wb_fifo
//  Description : Secondary writeback buffer. DEPTH entries, each with its own
//                valid bit so entries can be squashed in place by destination.
//                A squashed head is skipped (pointer advances, nothing output).
//  Ports       : clk, rst_n (sync, active-low), flush
//                push/push_rd/push_data  - enqueue (caller guarantees room)
//                pop                     - consume a valid head this cycle
//                squash_en/squash_rd     - invalidate all entries with that rd
//                head_valid/head_rd/head_data - live head entry
//                full, adv (head pointer advances this cycle)
//                ent_valid/ent_rd        - per-entry view for hazard masks
//  Revision    : 1.0 - initial release
// ============================================================================
module rip_wb_fifo #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [4:0]        push_rd,
    input  logic [XLEN-1:0]   push_data,
    input  logic              pop,
    input  logic              squash_en,
    input  logic [4:0]        squash_rd,
    output logic              head_valid,
    output logic [4:0]        head_rd,
    output logic [XLEN-1:0]   head_data,
    output logic              full,
    output logic              adv,
    output logic [DEPTH-1:0]  ent_valid,
    output logic [DEPTH*5-1:0] ent_rd
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       r_rd_ptr;
    logic [AW:0]       r_wr_ptr;
    logic [4:0]        r_rd   [DEPTH];
    logic [XLEN-1:0]   r_data [DEPTH];
    logic [DEPTH-1:0]  r_vld;
    logic [DEPTH-1:0]  w_vld_nxt;
    logic [AW-1:0]     w_head_idx;
    logic [AW-1:0]     w_wr_idx;
    logic              w_empty;
    logic              w_skip;

    assign w_head_idx = r_rd_ptr[AW-1:0];
    assign w_wr_idx   = r_wr_ptr[AW-1:0];
    assign w_empty    = (r_rd_ptr == r_wr_ptr);
    assign full       = (r_rd_ptr[AW] != r_wr_ptr[AW]) &&
                        (r_rd_ptr[AW-1:0] == r_wr_ptr[AW-1:0]);

    assign head_valid = !w_empty && r_vld[w_head_idx];
    assign head_rd    = r_rd[w_head_idx];
    assign head_data  = r_data[w_head_idx];

    // An occupied slot whose valid bit was cleared by a squash is dropped
    // without producing a write.
    assign w_skip = !w_empty && !r_vld[w_head_idx];
    assign adv    = (pop && head_valid) || w_skip;

    // Valid bits are the single source of truth for pend_mask, so every slot
    // outside the occupied window is kept clear (pop, skip and flush clear).
    always_comb begin
        w_vld_nxt = r_vld;
        for (int i = 0; i < DEPTH; i++) begin
            if (squash_en && (r_rd[i] == squash_rd)) begin
                w_vld_nxt[i] = 1'b0;
            end
        end
        if (adv) begin
            w_vld_nxt[w_head_idx] = 1'b0;
        end
        if (push) begin
            w_vld_nxt[w_wr_idx] = 1'b1;
        end
        if (flush) begin
            w_vld_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_vld    <= '0;
        end else begin
            r_vld    <= w_vld_nxt;
            r_rd_ptr <= flush ? r_wr_ptr : (r_rd_ptr + {{AW{1'b0}}, adv});
            r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, push};
        end
    end

    // Payload storage carries no reset; validity lives in r_vld.
    always_ff @(posedge clk) begin
        if (push) begin
            r_rd[w_wr_idx]   <= push_rd;
            r_data[w_wr_idx] <= push_data;
        end
    end

    assign ent_valid = r_vld;

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        assign ent_rd[g*5 +: 5] = r_rd[g];
    end

endmodule
`default_nettype wire

// File: rtl/rip_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rip_wb_arbiter
//  Description : Register-file write-port arbiter. The in-order MA result
//                always wins; long-latency results are buffered and drained
//                when the port is free. Primary writes squash older buffered
//                results to the same register (WAW).
//  Ports       : clk, rst_n (sync, active-low)
//                pri_valid/pri_rd/pri_data          - primary writeback
//                sec_valid/sec_ready/sec_rd/sec_data - secondary handshake
//                flush                               - drop buffered results
//                wen/ma_rd_num/wdata                 - registered RF write
//                pend_mask                           - buffered destinations
//                perf_sec_stall_cnt                  - stall statistic
//  Options     : RIP_WB_PERF_EN enables the saturating stall counter;
//                otherwise perf_sec_stall_cnt is constant zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module rip_wb_arbiter #(
    parameter int SEC_DEPTH = 4,
    parameter int XLEN      = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pri_valid,
    input  logic [4:0]      pri_rd,
    input  logic [XLEN-1:0] pri_data,
    input  logic            sec_valid,
    output logic            sec_ready,
    input  logic [4:0]      sec_rd,
    input  logic [XLEN-1:0] sec_data,
    input  logic            flush,
    output logic            wen,
    output logic [4:0]      ma_rd_num,
    output logic [XLEN-1:0] wdata,
    output logic [31:0]     pend_mask,
    output logic [31:0]     perf_sec_stall_cnt
);
    import rip_wb_pkg::*;

    logic                   w_pri_eff;
    logic                   w_push;
    logic                   w_head_valid;
    logic [4:0]             w_head_rd;
    logic [XLEN-1:0]        w_head_data;
    logic                   w_full;
    logic                   w_adv;
    logic [SEC_DEPTH-1:0]   w_ent_valid;
    logic [SEC_DEPTH*5-1:0] w_ent_rd;
    logic [NUM_REGS-1:0]    w_pend;

    logic                   r_wen;
    logic [4:0]             r_rd_num;
    logic [XLEN-1:0]        r_wdata;

    assign w_pri_eff = pri_valid && (pri_rd != REG_X0);

    // Ready may depend on this cycle's head advance but never on sec_valid.
    assign sec_ready = !flush && (!w_full || w_adv);

    // x0 results and results overwritten by the concurrent primary write are
    // accepted but never stored.
    assign w_push = sec_valid && sec_ready && (sec_rd != REG_X0) &&
                    !(w_pri_eff && (sec_rd == pri_rd));

    rip_wb_fifo #(
        .DEPTH (SEC_DEPTH),
        .XLEN  (XLEN)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .push       (w_push),
        .push_rd    (sec_rd),
        .push_data  (sec_data),
        .pop        (!w_pri_eff),
        .squash_en  (w_pri_eff),
        .squash_rd  (pri_rd),
        .head_valid (w_head_valid),
        .head_rd    (w_head_rd),
        .head_data  (w_head_data),
        .full       (w_full),
        .adv        (w_adv),
        .ent_valid  (w_ent_valid),
        .ent_rd     (w_ent_rd)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wen    <= 1'b0;
            r_rd_num <= '0;
            r_wdata  <= '0;
        end else if (w_pri_eff) begin
            r_wen    <= 1'b1;
            r_rd_num <= pri_rd;
            r_wdata  <= pri_data;
        end else if (w_head_valid) begin
            r_wen    <= 1'b1;
            r_rd_num <= w_head_rd;
            r_wdata  <= w_head_data;
        end else begin
            r_wen    <= 1'b0;
        end
    end

    assign wen       = r_wen;
    assign ma_rd_num = r_rd_num;
    assign wdata     = r_wdata;

    always_comb begin
        w_pend = '0;
        for (int i = 0; i < SEC_DEPTH; i++) begin
            if (w_ent_valid[i]) begin
                w_pend = w_pend | rd_onehot(w_ent_rd[i*5 +: 5]);
            end
        end
        w_pend[REG_X0] = 1'b0;
    end

    assign pend_mask = w_pend;

`ifdef RIP_WB_PERF_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_head_valid && w_pri_eff && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign perf_sec_stall_cnt = r_stall_cnt;
`else
    assign perf_sec_stall_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rip_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rip_wb_arbiter
//  Description : Self-checking bench for rip_wb_arbiter: a directed vector
//                table, directed multi-cycle sequences and a randomized run,
//                all compared against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rip_wb_arbiter;
    import rip_wb_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pri_valid;
    logic [4:0]  pri_rd;
    logic [31:0] pri_data;
    logic        sec_valid;
    logic        sec_ready;
    logic [4:0]  sec_rd;
    logic [31:0] sec_data;
    logic        flush;
    logic        wen;
    logic [4:0]  ma_rd_num;
    logic [31:0] wdata;
    logic [31:0] pend_mask;
    logic [31:0] perf_sec_stall_cnt;

    always #5 clk = ~clk;

    rip_wb_arbiter #(.SEC_DEPTH(DEPTH), .XLEN(32)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .pri_valid          (pri_valid),
        .pri_rd             (pri_rd),
        .pri_data           (pri_data),
        .sec_valid          (sec_valid),
        .sec_ready          (sec_ready),
        .sec_rd             (sec_rd),
        .sec_data           (sec_data),
        .flush              (flush),
        .wen                (wen),
        .ma_rd_num          (ma_rd_num),
        .wdata              (wdata),
        .pend_mask          (pend_mask),
        .perf_sec_stall_cnt (perf_sec_stall_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // ---------------- reference model: list of buffered results -----------
    typedef struct {
        wb_req_t req;
        bit      alive;
    } ent_t;

    ent_t        q[$];
    bit          m_wen;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic [31:0] m_cnt;

    // observed outputs at the last check point
    logic        o_wen, o_ready;
    logic [4:0]  o_rd;
    logic [31:0] o_data, o_mask, o_perf;
    bit          check_model = 1'b1;

    function automatic logic [31:0] model_mask();
        logic [31:0] m;
        m = 32'd0;
        foreach (q[i]) if (q[i].alive) m[q[i].req.rd] = 1'b1;
        return m;
    endfunction

    task automatic step(input logic r, input logic pv, input logic [4:0] prd,
                        input logic [31:0] pd, input logic sv, input logic [4:0] srd,
                        input logic [31:0] sd, input logic fl);
        bit eff, live, adv, rdy;
        @(negedge clk);
        rst_n = r; pri_valid = pv; pri_rd = prd; pri_data = pd;
        sec_valid = sv; sec_rd = srd; sec_data = sd; flush = fl;
        #1;
        o_wen = wen; o_rd = ma_rd_num; o_data = wdata; o_ready = sec_ready;
        o_mask = pend_mask; o_perf = perf_sec_stall_cnt;

        eff  = pv && (prd != 5'd0);
        live = (q.size() > 0) && q[0].alive;
        adv  = (q.size() > 0) && (!q[0].alive || !eff);
        rdy  = !fl && ((q.size() < DEPTH) || adv);

        if (check_model) begin
            chk("m_wen", {31'd0, o_wen}, {31'd0, m_wen});
            if (m_wen) begin
                chk("m_rd", {27'd0, o_rd}, {27'd0, m_rd});
                chk("m_data", o_data, m_data);
            end
            chk("m_ready", {31'd0, o_ready}, {31'd0, rdy});
            chk("m_mask", o_mask, model_mask());
`ifdef RIP_WB_PERF_EN
            chk("m_perf", o_perf, m_cnt);
`else
            chk("m_perf", o_perf, 32'd0);
`endif
        end

        if (!r) begin
            q.delete();
            m_wen = 0; m_rd = '0; m_data = '0; m_cnt = '0;
        end else begin
            if (live && eff && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (eff) begin
                m_wen = 1; m_rd = prd; m_data = pd;
            end else if (live) begin
                m_wen = 1; m_rd = q[0].req.rd; m_data = q[0].req.data;
            end else begin
                m_wen = 0;
            end
            if (adv) void'(q.pop_front());
            if (eff) foreach (q[i]) if (q[i].req.rd == prd) q[i].alive = 0;
            if (fl) q.delete();
            if (sv && rdy && srd != 5'd0 && !(eff && srd == prd)) begin
                ent_t e;
                e.req.rd = srd; e.req.data = sd; e.alive = 1;
                q.push_back(e);
            end
        end
    endtask

    task automatic idle();
        step(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        check_model = 0;
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        check_model = 1;
    endtask

    // ---------------- directed vector table --------------------------------
    typedef struct {
        logic        pv;
        logic [4:0]  prd;
        logic [31:0] pd;
        logic        sv;
        logic [4:0]  srd;
        logic [31:0] sd;
        logic        e_wen;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        logic        e_rdy;
        logic [31:0] e_mask;
    } vec_t;

    vec_t vt[10];

    int cnt_a, cnt_b;
    logic [4:0] seen[$];

    initial begin
        rst_n = 0; pri_valid = 0; pri_rd = 0; pri_data = 0;
        sec_valid = 0; sec_rd = 0; sec_data = 0; flush = 0;
        m_wen = 0; m_rd = 0; m_data = 0; m_cnt = 0;

        //          pv prd  pd            sv srd  sd       wen rd  data    rdy mask
        vt[0] = '{0, 0, 32'h0,        1, 5, 32'hA5, 0, 0, 32'h0,  1, 32'h0};
        vt[1] = '{0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 32'h0,  1, 32'h20};
        vt[2] = '{0, 0, 32'h0,        0, 0, 32'h0,  1, 5, 32'hA5, 1, 32'h0};
        vt[3] = '{0, 0, 32'h0,        0, 0, 32'h0,  0, 5, 32'hA5, 1, 32'h0};
        vt[4] = '{1, 0, 32'hFFFFFFFF, 1, 4, 32'h44, 0, 5, 32'hA5, 1, 32'h0};
        vt[5] = '{1, 0, 32'hFFFFFFFF, 0, 0, 32'h0,  0, 5, 32'hA5, 1, 32'h10};
        vt[6] = '{0, 0, 32'h0,        0, 0, 32'h0,  1, 4, 32'h44, 1, 32'h0};
        vt[7] = '{1, 3, 32'h33,       1, 3, 32'h99, 0, 4, 32'h44, 1, 32'h0};
        vt[8] = '{0, 0, 32'h0,        1, 0, 32'h77, 1, 3, 32'h33, 1, 32'h0};
        vt[9] = '{0, 0, 32'h0,        0, 0, 32'h0,  0, 3, 32'h33, 1, 32'h0};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1, vt[i].pv, vt[i].prd, vt[i].pd, vt[i].sv, vt[i].srd, vt[i].sd, 0);
            chk($sformatf("t%0d_wen", i), {31'd0, o_wen}, {31'd0, vt[i].e_wen});
            chk($sformatf("t%0d_rd", i), {27'd0, o_rd}, {27'd0, vt[i].e_rd});
            chk($sformatf("t%0d_data", i), o_data, vt[i].e_data);
            chk($sformatf("t%0d_rdy", i), {31'd0, o_ready}, {31'd0, vt[i].e_rdy});
            chk($sformatf("t%0d_mask", i), o_mask, vt[i].e_mask);
        end

        // ---- primary burst with four secondary pushes, then drain ----------
        do_reset();
        cnt_a = 0;
        for (int i = 0; i < 10; i++) begin
            logic sv;
            sv = (cnt_a < 4);
            step(1, 1, 3, i, sv, 5'(7 + cnt_a), 32'h700 + cnt_a, 0);
            if (sv && o_ready) cnt_a++;
            if (i == 5) chk("burst_ready_low", {31'd0, o_ready}, 32'd0);
        end
        chk("burst_accepted", cnt_a, 4);
        seen.delete();
        for (int i = 0; i < 8; i++) begin
            idle();
`ifdef RIP_WB_PERF_EN
            if (i == 0) chk("burst_stall_cnt", o_perf, 32'd9);
`else
            if (i == 0) chk("burst_stall_cnt", o_perf, 32'd0);
`endif
            if (o_wen && o_rd != 5'd3) seen.push_back(o_rd);
        end
        chk("drain_count", seen.size(), 4);
        for (int i = 0; i < 4 && i < seen.size(); i++)
            chk($sformatf("drain_order%0d", i), {27'd0, seen[i]}, 32'(7 + i));

        // ---- WAW squash of a buffered entry --------------------------------
        do_reset();
        step(1, 1, 3, 1, 1, 12, 32'hC0C, 0);
        step(1, 1, 3, 2, 0, 0, 0, 0);
        chk("squash_mask_before", {31'd0, o_mask[12]}, 32'd1);
        step(1, 1, 12, 32'h1212, 0, 0, 0, 0);
        idle();
        chk("squash_mask_after", {31'd0, o_mask[12]}, 32'd0);
        cnt_a = 0; cnt_b = 0;
        if (o_wen && o_rd == 5'd12) begin
            if (o_data == 32'h1212) cnt_b++; else cnt_a++;
        end
        for (int i = 0; i < 5; i++) begin
            idle();
            if (o_wen && o_rd == 5'd12) begin
                if (o_data == 32'h1212) cnt_b++; else cnt_a++;
            end
        end
        chk("squash_stale_writes", cnt_a, 0);
        chk("squash_primary_writes", cnt_b, 1);

        // ---- flush on a full buffer with a concurrent primary --------------
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 1, 3, i, 1, 5'(20 + i), 32'h2000 + i, 0);
        step(1, 1, 3, 9, 0, 0, 0, 0);
        chk("flush_full_ready", {31'd0, o_ready}, 32'd0);
        step(1, 1, 6, 32'h66, 1, 24, 32'h24, 1);
        chk("flush_ready", {31'd0, o_ready}, 32'd0);
        idle();
        chk("flush_wen", {31'd0, o_wen}, 32'd1);
        chk("flush_rd", {27'd0, o_rd}, 32'd6);
        chk("flush_data", o_data, 32'h66);
        chk("flush_mask", o_mask, 32'd0);
        cnt_a = 0;
        for (int i = 0; i < 6; i++) begin
            idle();
            if (o_wen && o_rd >= 5'd20 && o_rd <= 5'd24) cnt_a++;
        end
        chk("flush_stale_writes", cnt_a, 0);

        // ---- reset while holding entries and driving a write ---------------
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 1, 3, 32'h30 + i, 1, 5'(13 + i), 32'h1300 + i, 0);
        check_model = 0;
        step(0, 1, 3, 32'h40, 0, 0, 0, 0);
        check_model = 1;
        chk("rst_pre_wen", {31'd0, o_wen}, 32'd1);
        idle();
        chk("rst_wen", {31'd0, o_wen}, 32'd0);
        chk("rst_rd", {27'd0, o_rd}, 32'd0);
        chk("rst_data", o_data, 32'd0);
        chk("rst_ready", {31'd0, o_ready}, 32'd1);
        chk("rst_mask", o_mask, 32'd0);

        // ---- randomized traffic against the model --------------------------
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic r, pv, sv, fl;
            r  = ($urandom_range(0, 199) != 0);
            pv = ($urandom_range(0, 99) < 45);
            sv = ($urandom_range(0, 99) < 60);
            fl = ($urandom_range(0, 49) == 0);
            step(r, pv, 5'($urandom_range(0, 7)), $urandom, sv,
                 5'($urandom_range(0, 7)), $urandom, fl);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rip_wb_arbiter.md
Name: rip_wb_arbiter

Overview:
- Drives the register-file write port (wen, ma_rd_num, wdata) from two writeback sources.
  - Primary: the in-order MA-stage result. It always has priority and has no backpressure.
  - Secondary: long-latency results (mul/div, load miss). These arrive on a valid/ready handshake and are buffered in a small FIFO.
- Sits between the MA stage plus the long-latency units and the register file.
- Exports a pending-destination mask to the issue hazard logic.

Parameters:
- SEC_DEPTH, 4, number of secondary FIFO entries (power of 2, range 2..16).
- XLEN, 32, data width.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset; synchronous, active-low
- pri_valid  input  1  primary writeback present this cycle
- pri_rd  input  5  primary destination register
- pri_data  input  XLEN  primary result
- sec_valid  input  1  secondary result offered
- sec_ready  output  1  secondary result accepted this cycle
- sec_rd  input  5  secondary destination register
- sec_data  input  XLEN  secondary result
- flush  input  1  discard all buffered secondary entries
- wen  output  1  register-file write enable
- ma_rd_num  output  5  register-file write index
- wdata  output  XLEN  register-file write data
- pend_mask  output  32  bit i set when any valid FIFO entry targets x[i]
- perf_sec_stall_cnt  output  32  stall statistic (see Optional Feature)

Behaviour:
- Reset values: wen=0, ma_rd_num=0, wdata=0, FIFO empty, pend_mask=0, perf counter=0.
  - Reset mid-operation drops all buffered entries without writing them.
- Outputs wen, ma_rd_num and wdata are registered: a write selected in cycle N appears on the port in cycle N+1.
- Per-cycle selection:
  - A primary write is "effective" when pri_valid && pri_rd!=0.
  - If the primary write is effective, it wins: wen<=1, ma_rd_num<=pri_rd, wdata<=pri_data.
  - Otherwise, if the FIFO head is valid, pop it to the port.
  - Otherwise wen<=0; ma_rd_num and wdata hold their previous values.
- x0: primary or secondary writes with rd=0 never assert wen.
  - A secondary write with rd=0 is accepted and dropped; it is not enqueued.
- sec_ready = !full || pop_this_cycle. Enqueue happens when sec_valid && sec_ready.
  - Simultaneous push and pop on a full FIFO is legal; occupancy is unchanged.
  - Enqueue on an empty FIFO does not bypass to the port in the same cycle; the earliest write is the following cycle.
- WAW squash:
  - Issue guarantees that a secondary result is older than any concurrent primary write to the same rd.
  - An effective primary write clears the valid bit of every FIFO entry whose rd == pri_rd.
  - An entry being enqueued in the same cycle with sec_rd == pri_rd is also dropped.
  - A squashed head is skipped: the pointer advances with no write, costing at most one idle cycle per squashed entry.
- Pointers:
  - clog2(SEC_DEPTH)+1-bit read/write pointers with wrap.
  - full when the pointer MSBs differ and the lower bits are equal; empty when the pointers are equal.
- flush: empties the FIFO (rd_ptr<=wr_ptr) and forces sec_ready=0 that cycle.
  - A primary write in the same cycle still proceeds.
  - pend_mask is 0 the following cycle.
- pend_mask is combinational: the OR over valid entries of the one-hot rd. Bit 0 is always 0.

Optional Feature:
- Macro: RIP_WB_PERF_EN.
- Defined:
  - perf_sec_stall_cnt increments (saturating at 0xFFFFFFFF) on each cycle where the FIFO head is valid and an effective primary write blocks it.
  - The counter clears on reset.
- Undefined: perf_sec_stall_cnt is tied to 0 and no counter flops are inferred.

Decomposition:
- Package rip_wb_pkg:
  - typedef wb_req_t {logic [4:0] rd; logic [XLEN-1:0] data;}
  - constant REG_X0 = 5'd0
  - constant NUM_REGS = 32
- Sub-module rip_wb_fifo: a DEPTH-entry FIFO with per-entry valid bits, a squash-by-rd port and a head-skip.
  - The top level holds priority selection, the output registers, pend_mask and the perf counter.

Test Plan:
- Reset, then sec_valid with rd=5, data=0xA5, no primary → cycle+2: wen=1, ma_rd_num=5, wdata=0xA5; pend_mask bit5=1 for one cycle.
- Primary write rd=3 every cycle for 10 cycles, with 4 secondary pushes (rd 7..10) → sec_ready drops after 4 accepted pushes.
  - With RIP_WB_PERF_EN, stall count = 10 minus the cycles the FIFO was empty.
  - After the primary stops, writes to 7, 8, 9, 10 appear in order.
- Secondary rd=12 buffered behind a primary burst, then an effective primary write to rd=12 → the rd=12 entry is never written; pend_mask bit12 clears the next cycle.
- Primary rd=0, data=0xFFFF_FFFF with a FIFO head rd=4 → that cycle the head is popped; wen never targets x0.
- FIFO full (4 entries), assert flush while pri_valid rd=6 → rd=6 is written; FIFO is empty; pend_mask=0; none of the flushed entries is ever written.
- rst_n low while the FIFO holds 3 entries and wen=1 → next cycle wen=0, ma_rd_num=0, wdata=0, sec_ready=1.
